// File: rtl/uart_pkg.sv
// Shared UART constants, arbiter FSM encoding and a small modular-index helper.
package uart_pkg;

    localparam int unsigned CLK_FREQ     = 50000000;
    localparam int unsigned UART_BPS     = 115200;
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / UART_BPS;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone
    } arb_state_e;

    function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle; master is the arbiter side.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4
) ();

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_lock;
    logic [N_REQ-1:0]   req_ready;
    logic               uart_tx_en;
    logic [7:0]         uart_tx_data;
    logic               uart_tx_busy;

    modport master (
        input  req_valid,
        input  req_data,
        input  req_lock,
        input  uart_tx_busy,
        output req_ready,
        output uart_tx_en,
        output uart_tx_data
    );

    modport slave (
        output req_valid,
        output req_data,
        output req_lock,
        output uart_tx_busy,
        input  req_ready,
        input  uart_tx_en,
        input  uart_tx_data
    );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first valid index at or after i_ptr, with wrap-around.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_valid,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_grant,
    output logic [$clog2(N_REQ)-1:0] o_idx,
    output logic                     o_any
);

    localparam int unsigned IdW = $clog2(N_REQ);

    logic [IdW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_cand = IdW'(wrap_add(32'(i_ptr), k, N_REQ));
            if (!o_any && i_valid[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter, with locked bursts, a burst cap
// and a watchdog on the transmitter's busy response.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_tx_arbiter_if.master        bus,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     active,
    output logic                     err_timeout
);

    localparam int unsigned IdW    = $clog2(N_REQ);
    localparam int unsigned BurstW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned ToW    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [IdW-1:0]    LastId    = IdW'(N_REQ - 1);
    localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);
    localparam logic [ToW-1:0]    ToLast    = ToW'(BUSY_TIMEOUT - 1);
    localparam logic [N_REQ-1:0]  OneHot0   = {{(N_REQ - 1){1'b0}}, 1'b1};

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic [IdW-1:0]    r_grant;
    logic [IdW-1:0]    r_rr_ptr;
    logic [7:0]        r_data;
    logic [BurstW-1:0] r_burst_cnt;
    logic [ToW-1:0]    r_to_cnt;

    logic [N_REQ-1:0]  w_pick_onehot;
    logic [IdW-1:0]    w_pick_id;
    logic              w_pick_any;
    logic [7:0]        w_pick_data;
    logic [7:0]        w_grant_data;
    logic [IdW-1:0]    w_grant_inc;
    logic              w_busy;
    logic              w_launch_idle;
    logic              w_to_expire;
    logic              w_continue;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr_arbiter (
        .i_valid(bus.req_valid),
        .i_ptr  (r_rr_ptr),
        .o_grant(w_pick_onehot),
        .o_idx  (w_pick_id),
        .o_any  (w_pick_any)
    );

    always_comb begin
        w_pick_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick_onehot[i]) begin
                w_pick_data = w_pick_data | bus.req_data[8*i +: 8];
            end
        end
    end

    assign w_busy        = bus.uart_tx_busy;
    assign w_grant_data  = bus.req_data[{r_grant, 3'b000} +: 8];
    assign w_grant_inc   = (r_grant == LastId) ? '0 : r_grant + 1'b1;
    assign w_launch_idle = w_pick_any && !w_busy;
    assign w_to_expire   = !w_busy && (r_to_cnt == ToLast);
    // Lock is only honoured while the grantee still has a byte and the cap is not reached.
    assign w_continue    = bus.req_lock[r_grant] && bus.req_valid[r_grant] &&
                           (r_burst_cnt < BurstLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            StIdle: begin
                if (w_launch_idle) w_next_state = StLaunch;
            end
            StLaunch: begin
                w_next_state = StWaitBusy;
            end
            StWaitBusy: begin
                if (w_busy) begin
                    w_next_state = StWaitDone;
                end else if (w_to_expire) begin
                    w_next_state = StIdle;
                end
            end
            StWaitDone: begin
                if (!w_busy) w_next_state = w_continue ? StLaunch : StIdle;
            end
            default: w_next_state = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_data      <= '0;
            r_burst_cnt <= '0;
            r_to_cnt    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_launch_idle) begin
                        r_grant     <= w_pick_id;
                        r_data      <= w_pick_data;
                        r_burst_cnt <= '0;
                    end
                end
                StLaunch: begin
                    r_to_cnt <= '0;
                end
                StWaitBusy: begin
                    if (!w_busy) begin
                        if (w_to_expire) begin
                            r_rr_ptr    <= w_grant_inc;
                            r_burst_cnt <= '0;
                            r_to_cnt    <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                end
                StWaitDone: begin
                    if (!w_busy) begin
                        if (w_continue) begin
                            r_data      <= w_grant_data;
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        end else begin
                            r_burst_cnt <= '0;
                            r_rr_ptr    <= w_grant_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.uart_tx_en = 1'b0;
        bus.req_ready  = '0;
        err_timeout    = 1'b0;
        active         = (r_state != StIdle);
        case (r_state)
            StLaunch: begin
                bus.uart_tx_en = 1'b1;
                bus.req_ready  = OneHot0 << r_grant;
            end
            StWaitBusy: begin
                err_timeout = w_to_expire;
            end
            default: ;
        endcase
    end

    assign bus.uart_tx_data = r_data;
    assign grant_id         = r_grant;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter MAX_BURST, default 16: maximum consecutive bytes one locked requester may send before the grant must be re-arbitrated.
REQ-003 Parameter BUSY_TIMEOUT, default 4: cycles allowed after launch for uart_tx_busy to rise.
REQ-004 Port list: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
REQ-005 Requester ports:
- req_valid  in  N_REQ  per-requester byte valid
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_lock  in  N_REQ  keep grant for the next byte (message atomicity)
- req_ready  out  N_REQ  one-hot one-cycle accept pulse
REQ-006 Transmitter-side ports:
- uart_tx_en  out  1  one-cycle launch strobe to the transmitter
- uart_tx_data  out  8  byte to the transmitter
- uart_tx_busy  in  1  transmitter busy
REQ-007 Status ports:
- grant_id  out  clog2(N_REQ)  current or last grantee
- active  out  1  high in any state other than IDLE
- err_timeout  out  1  one-cycle pulse when the busy timeout expires

Function
REQ-008 The FSM SHALL have four states:
- IDLE
- LAUNCH (exactly 1 cycle)
- WAIT_BUSY
- WAIT_DONE
REQ-009 IDLE: if any req_valid is high and uart_tx_busy=0, the block SHALL select g round-robin starting at rr_ptr, latch req_data[g] into uart_tx_data, set grant_id=g, and go to LAUNCH on that edge.
REQ-010 LAUNCH: uart_tx_en=1 and req_ready[g]=1 for this single cycle only; next state WAIT_BUSY.
REQ-011 Protocol rule: a requester SHALL hold req_valid and req_data stable until it sees req_ready; the transfer completes in the req_ready cycle.
REQ-012 WAIT_BUSY: on uart_tx_busy=1, go to WAIT_DONE. If busy stays low for BUSY_TIMEOUT cycles, pulse err_timeout, set rr_ptr=g+1 (mod N_REQ), and go to IDLE.
REQ-013 WAIT_DONE: on uart_tx_busy=0:
- If req_lock[g]=1, req_valid[g]=1 and burst_cnt<MAX_BURST-1: latch req_data[g], increment burst_cnt, go to LAUNCH.
- Otherwise: clear burst_cnt, set rr_ptr=g+1 (mod N_REQ), go to IDLE.
REQ-014 uart_tx_en SHALL never be asserted while uart_tx_busy=1 and SHALL never be high for two consecutive cycles.
REQ-015 Latency: valid sampled in IDLE at edge t gives req_ready and uart_tx_en high in cycle t+1. Byte-to-byte gap inside a locked burst is 1 cycle after busy falls.
REQ-016 Round-robin: after a grant to g, requester g has the lowest priority. When several requesters are valid simultaneously, the first valid index at or after rr_ptr, with wrap-around, wins.
REQ-017 A req_valid drop by a non-granted requester SHALL have no effect. req_lock is sampled only in WAIT_DONE.
REQ-018 At the MAX_BURST limit the grant SHALL be released even if req_lock[g]=1.
REQ-019 rr_ptr and burst_cnt SHALL wrap modulo N_REQ and MAX_BURST respectively and be sized by clog2.

Reset
REQ-020 On rst_n=0, asynchronously and independent of clk: state=IDLE; uart_tx_en=0, uart_tx_data=0, req_ready=0, grant_id=0, active=0, err_timeout=0, rr_ptr=0, burst_cnt=0.
REQ-021 Reset mid-transfer SHALL abort without any further strobe. The first grant after reset SHALL start at requester 0.

Structure
REQ-022 Shared package uart_pkg SHALL hold the FSM state encoding and the default UART constants (CLK_FREQ=50000000, UART_BPS=115200).
REQ-023 A combinational sub-module rr_arbiter(N_REQ) SHALL compute the one-hot pick from req_valid and rr_ptr. The FSM, latches and counters stay in uart_tx_arbiter.

Verification
REQ-024 The bench SHALL cover these directed scenarios, each against the existing transmitter at CLK_FREQ/UART_BPS defaults (434 clocks/bit):
- Single byte: req_valid[2]=1, data 0x5A -> one uart_tx_en pulse, req_ready=0100, serial frame 0,0,1,0,1,1,0,1,0,1, active low again after busy falls.
- Contention: all four valid, data 0x10..0x13, no lock -> transmission order 0,1,2,3. A re-asserted requester 0 is served only after 3.
- Locked burst: requester 1 locked with 3 bytes 0xA1,0xA2,0xA3 while requester 0 valid -> A1,A2,A3 sent back to back, then requester 0.
- Burst cap: MAX_BURST=4, requester 3 locked with 6 bytes, requester 0 valid -> 4 bytes from 3, one from 0, then the remaining 2 from 3.
- Timeout: busy tied low -> err_timeout pulses 4 cycles after LAUNCH, FSM back to IDLE, rr_ptr advanced.
- Reset during WAIT_DONE -> all outputs zero immediately, no uart_tx_en until a new request, next grant goes to the lowest valid index.
